// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default sizes, address-width helper and parameter legality checks.
// Used by both the single-clock and dual-clock FIFOs.
package fifo_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_DEPTH  = 16;

    // Smallest r such that 2**r >= n.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 31; i++) begin
            if ((32'd1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    function automatic bit is_pow2(input int unsigned n);
        return (n != 0) && ((n & (n - 1)) == 0);
    endfunction

    function automatic bit params_legal(input int unsigned depth, input int unsigned af,
                                        input int unsigned ae);
        return is_pow2(depth) && (depth >= 4) && (af >= 1) && (af <= depth) && (ae < depth);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// DATA_W x DEPTH register array: one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    localparam int unsigned AW    = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy count, threshold flags, sticky error flags
// and selectable standard / first-word-fall-through read mode.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned DEPTH     = DEF_DEPTH,
    parameter int unsigned AF_THRESH = DEPTH - 2,
    parameter int unsigned AE_THRESH = 2,
    parameter int unsigned FWFT      = 0,
    localparam int unsigned AW       = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              w_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              r_en,
    input  logic              err_clr,
    output logic [DATA_W-1:0] data_out,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [AW:0]       count,
    output logic              overflow,
    output logic              underflow
);

    if (!params_legal(DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_params
        $error("sync_fifo_param: illegal DEPTH or threshold parameters");
    end

    localparam logic [AW:0] AF_LVL = AF_THRESH[AW:0];
    localparam logic [AW:0] AE_LVL = AE_THRESH[AW:0];

    logic [AW:0]       wptr_q, rptr_q;
    logic              w_acc, r_acc;
    logic              overflow_q, underflow_q;
    logic [DATA_W-1:0] rd_data;

    // Flags come from registered pointers only, so acceptance never depends on same-cycle pops.
    assign full         = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty        = (wptr_q == rptr_q);
    assign count        = wptr_q - rptr_q;
    assign almost_full  = (count >= AF_LVL);
    assign almost_empty = (count <= AE_LVL);
    assign w_acc        = w_en && !full;
    assign r_acc        = r_en && !empty;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (w_acc) wptr_q <= wptr_q + 1'b1;
            if (r_acc) rptr_q <= rptr_q + 1'b1;
        end
    end

    // A new error outranks a coincident clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (w_en && full)  overflow_q <= 1'b1;
            else if (err_clr)  overflow_q <= 1'b0;
            if (r_en && empty) underflow_q <= 1'b1;
            else if (err_clr)  underflow_q <= 1'b0;
        end
    end

    fifo_ram #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk  (clk),
        .we   (w_acc),
        .waddr(wptr_q[AW-1:0]),
        .wdata(data_in),
        .raddr(rptr_q[AW-1:0]),
        .rdata(rd_data)
    );

    if (FWFT == 0) begin : g_std
        logic [DATA_W-1:0] dout_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)     dout_q <= '0;
            else if (r_acc) dout_q <= rd_data;
        end
        assign data_out = dout_q;
    end else begin : g_fwft
        assign data_out = rd_data;
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param: one standard-mode and one FWFT instance.
module tb_sync_fifo_param;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       w_en, r_en, err_clr;
    logic [7:0] data_in, data_out;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0] count;

    logic       f_w_en, f_r_en, f_err_clr;
    logic [7:0] f_data_in, f_data_out;
    logic       f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow;
    logic [4:0] f_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sync_fifo_param #(.DATA_W(8), .DEPTH(16), .FWFT(0)) dut (
        .clk(clk), .rst_n(rst_n), .w_en(w_en), .data_in(data_in), .r_en(r_en),
        .err_clr(err_clr), .data_out(data_out), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    sync_fifo_param #(.DATA_W(8), .DEPTH(16), .FWFT(1)) dut_fwft (
        .clk(clk), .rst_n(rst_n), .w_en(f_w_en), .data_in(f_data_in), .r_en(f_r_en),
        .err_clr(f_err_clr), .data_out(f_data_out), .full(f_full), .empty(f_empty),
        .almost_full(f_almost_full), .almost_empty(f_almost_empty), .count(f_count),
        .overflow(f_overflow), .underflow(f_underflow)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        total++; if (count !== 5'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", count); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL rst_empty got=%b want=1", empty); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL rst_full got=%b want=0", full); end
        total++; if (almost_empty !== 1'b1) begin bad++; $display("FAIL rst_ae got=%b want=1", almost_empty); end
        total++; if (almost_full !== 1'b0) begin bad++; $display("FAIL rst_af got=%b want=0", almost_full); end
        total++; if ({overflow, underflow} !== 2'b00) begin bad++; $display("FAIL rst_err got=%b%b want=00", overflow, underflow); end
        total++; if (data_out !== 8'h00) begin bad++; $display("FAIL rst_dout got=%h want=00", data_out); end
        total++; if (f_empty !== 1'b1) begin bad++; $display("FAIL rst_f_empty got=%b want=1", f_empty); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            w_en = 1'b1; data_in = 8'h10 + i[7:0];
            step();
            w_en = 1'b0;
            total++; if (count !== 5'(i + 1)) begin bad++; $display("FAIL fill_count[%0d] got=%0d want=%0d", i, count, i + 1); end
            total++; if (almost_full !== (i + 1 >= 14)) begin bad++; $display("FAIL fill_af[%0d] got=%b want=%b", i, almost_full, i + 1 >= 14); end
            total++; if (almost_empty !== (i + 1 <= 2)) begin bad++; $display("FAIL fill_ae[%0d] got=%b want=%b", i, almost_empty, i + 1 <= 2); end
            total++; if (full !== (i == 15)) begin bad++; $display("FAIL fill_full[%0d] got=%b want=%b", i, full, i == 15); end
        end
        w_en = 1'b1; data_in = 8'hEE;
        step();
        w_en = 1'b0;
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b want=1", overflow); end
        total++; if (count !== 5'd16) begin bad++; $display("FAIL ovf_count got=%0d want=16", count); end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 16; i++) begin
            r_en = 1'b1;
            step();
            r_en = 1'b0;
            total++; if (data_out !== 8'h10 + i[7:0]) begin bad++; $display("FAIL drain_data[%0d] got=%h want=%h", i, data_out, 8'h10 + i[7:0]); end
            total++; if (count !== 5'(15 - i)) begin bad++; $display("FAIL drain_count[%0d] got=%0d want=%0d", i, count, 15 - i); end
        end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL drain_empty got=%b want=1", empty); end
        r_en = 1'b1;
        step();
        r_en = 1'b0;
        total++; if (underflow !== 1'b1) begin bad++; $display("FAIL unf_flag got=%b want=1", underflow); end
        total++; if (data_out !== 8'h1F) begin bad++; $display("FAIL unf_hold got=%h want=1f", data_out); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b want=1", overflow); end
    endtask

    task automatic test_simultaneous();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        total++; if ({overflow, underflow} !== 2'b00) begin bad++; $display("FAIL errclr got=%b%b want=00", overflow, underflow); end
        for (int i = 0; i < 8; i++) begin
            w_en = 1'b1; data_in = 8'h40 + i[7:0];
            step();
        end
        w_en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            w_en = 1'b1; r_en = 1'b1; data_in = 8'h48 + k[7:0];
            step();
            total++; if (data_out !== 8'h40 + k[7:0]) begin bad++; $display("FAIL simul_data[%0d] got=%h want=%h", k, data_out, 8'h40 + k[7:0]); end
            total++; if (count !== 5'd8) begin bad++; $display("FAIL simul_count[%0d] got=%0d want=8", k, count); end
        end
        w_en = 1'b0;
        for (int k = 0; k < 8; k++) begin
            r_en = 1'b1;
            step();
            total++; if (data_out !== 8'h4A + k[7:0]) begin bad++; $display("FAIL simul_tail[%0d] got=%h want=%h", k, data_out, 8'h4A + k[7:0]); end
        end
        r_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            w_en = 1'b1; data_in = 8'h60 + i[7:0];
            step();
        end
        total++; if (full !== 1'b1) begin bad++; $display("FAIL refill_full got=%b want=1", full); end
        w_en = 1'b1; r_en = 1'b1; data_in = 8'h99;
        step();
        w_en = 1'b0; r_en = 1'b0;
        total++; if (count !== 5'd15) begin bad++; $display("FAIL fullrw_count got=%0d want=15", count); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL fullrw_ovf got=%b want=1", overflow); end
        total++; if (data_out !== 8'h60) begin bad++; $display("FAIL fullrw_data got=%h want=60", data_out); end
        err_clr = 1'b1;
        step();
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL clr_ovf got=%b want=0", overflow); end
        err_clr = 1'b0; w_en = 1'b1; data_in = 8'h70;
        step();
        w_en = 1'b1; err_clr = 1'b1; data_in = 8'h98;
        step();
        w_en = 1'b0; err_clr = 1'b0;
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL setclr_ovf got=%b want=1", overflow); end
        total++; if (count !== 5'd16) begin bad++; $display("FAIL setclr_count got=%0d want=16", count); end
        for (int k = 0; k < 16; k++) begin
            r_en = 1'b1;
            step();
            total++; if (data_out !== 8'h61 + k[7:0]) begin bad++; $display("FAIL fullrw_drain[%0d] got=%h want=%h", k, data_out, 8'h61 + k[7:0]); end
        end
        r_en = 1'b0; err_clr = 1'b1;
        step();
        err_clr = 1'b0;
    endtask

    task automatic test_wrap();
        int wi, ri, occ, cyc;
        wi = 0; ri = 0; occ = 0; cyc = 0;
        while ((wi < 40 || occ != 0) && cyc < 400) begin
            w_en    = (wi < 40) && (occ < 16);
            data_in = wi[7:0];
            r_en    = (occ != 0) && ($urandom_range(0, 1) == 1);
            step();
            if (w_en) begin wi++; occ++; end
            if (r_en) begin
                occ--;
                total++; if (data_out !== ri[7:0]) begin bad++; $display("FAIL wrap_data[%0d] got=%h want=%h", ri, data_out, ri[7:0]); end
                ri++;
            end
            total++; if (count !== 5'(occ)) begin bad++; $display("FAIL wrap_count c%0d got=%0d want=%0d", cyc, count, occ); end
            total++; if ({full, empty} !== {occ == 16, occ == 0}) begin bad++; $display("FAIL wrap_flags c%0d got=%b%b want=%b%b", cyc, full, empty, occ == 16, occ == 0); end
            cyc++;
        end
        w_en = 1'b0; r_en = 1'b0;
        total++; if (ri != 40) begin bad++; $display("FAIL wrap_reads got=%0d want=40", ri); end
    endtask

    task automatic test_mid_reset();
        r_en = 1'b1;
        step();
        r_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            w_en = 1'b1; data_in = 8'h31 + i[7:0];
            step();
        end
        w_en = 1'b0; r_en = 1'b1;
        step();
        r_en = 1'b0;
        total++; if (count !== 5'd5) begin bad++; $display("FAIL mid_pre_count got=%0d want=5", count); end
        total++; if (data_out !== 8'h31) begin bad++; $display("FAIL mid_pre_data got=%h want=31", data_out); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (count !== 5'd0) begin bad++; $display("FAIL mid_count got=%0d want=0", count); end
        total++; if ({empty, full, almost_empty, almost_full} !== 4'b1010) begin bad++; $display("FAIL mid_flags got=%b%b%b%b want=1010", empty, full, almost_empty, almost_full); end
        total++; if ({overflow, underflow} !== 2'b00) begin bad++; $display("FAIL mid_err got=%b%b want=00", overflow, underflow); end
        total++; if (data_out !== 8'h00) begin bad++; $display("FAIL mid_dout got=%h want=00", data_out); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_fwft();
        f_w_en = 1'b1; f_data_in = 8'hA5;
        step();
        f_w_en = 1'b0;
        total++; if (f_empty !== 1'b0) begin bad++; $display("FAIL fwft_empty got=%b want=0", f_empty); end
        total++; if (f_data_out !== 8'hA5) begin bad++; $display("FAIL fwft_data got=%h want=a5", f_data_out); end
        f_r_en = 1'b1;
        step();
        f_r_en = 1'b0;
        total++; if (f_empty !== 1'b1) begin bad++; $display("FAIL fwft_pop_empty got=%b want=1", f_empty); end
        f_w_en = 1'b1; f_data_in = 8'h3C;
        step();
        f_data_in = 8'h5A;
        step();
        f_w_en = 1'b0;
        total++; if (f_data_out !== 8'h3C) begin bad++; $display("FAIL fwft_head got=%h want=3c", f_data_out); end
        f_r_en = 1'b1;
        step();
        f_r_en = 1'b0;
        total++; if (f_data_out !== 8'h5A) begin bad++; $display("FAIL fwft_next got=%h want=5a", f_data_out); end
        total++; if (f_count !== 5'd1) begin bad++; $display("FAIL fwft_count got=%0d want=1", f_count); end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        w_en = 1'b0; r_en = 1'b0; err_clr = 1'b0; data_in = 8'h00;
        f_w_en = 1'b0; f_r_en = 1'b0; f_err_clr = 1'b0; f_data_in = 8'h00;
        test_reset();
        test_fill();
        test_drain();
        test_simultaneous();
        test_wrap();
        test_mid_reset();
        test_fwft();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
